// File: rtl/nibble_pack_if.sv
// nibble_pack_if -- handshake bundle for nibble_pack_ctrl.
//   W          : nibble width; out_data is 2*W wide.
//   a_*        : low-half nibble producer (valid/data in, ready out of the packer).
//   b_*        : high-half nibble producer (valid/data in, ready out of the packer).
//   out_*      : packed word consumer (valid/data out of the packer, ready in).
//   master     : producers/consumer side (testbench or surrounding logic).
//   slave      : the packer itself.
interface nibble_pack_if #(
  parameter int W = 4
);
  logic           a_valid;
  logic [W-1:0]   a_data;
  logic           a_ready;
  logic           b_valid;
  logic [W-1:0]   b_data;
  logic           b_ready;
  logic           out_valid;
  logic [2*W-1:0] out_data;
  logic           out_ready;

  modport master (
    output a_valid, a_data, b_valid, b_data, out_ready,
    input  a_ready, b_ready, out_valid, out_data
  );

  modport slave (
    input  a_valid, a_data, b_valid, b_data, out_ready,
    output a_ready, b_ready, out_valid, out_data
  );
endinterface

// File: rtl/nibble_pack_ctrl.sv
// nibble_pack_ctrl -- collects one nibble from each of two requesters and
// emits the packed word {b_nibble, a_nibble} on a valid/ready output.
//   clk        : single clock, all state on the rising edge.
//   rst_n      : asynchronous active-low reset.
//   flush      : synchronous discard of partially collected nibbles; the
//                output register is left untouched.
//   bus        : nibble_pack_if.slave (a_*, b_*, out_* handshakes).
//   busy       : any nibble held or a word waiting on the output.
//   word_count : (only with NIBBLE_PACK_CNT_EN defined) 16-bit wrapping count
//                of output handshakes.
// Optional feature macro: NIBBLE_PACK_CNT_EN.
module nibble_pack_ctrl #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  nibble_pack_if.slave   bus,
  output logic           busy
`ifdef NIBBLE_PACK_CNT_EN
  ,
  output logic [15:0]    word_count
`endif
);

  // State is {a_have, b_have}; it is not stored separately.
  localparam logic [1:0] EMPTY  = 2'b00;
  localparam logic [1:0] HAVE_A = 2'b10;
  localparam logic [1:0] HAVE_B = 2'b01;
  localparam logic [1:0] BOTH   = 2'b11;

  logic [W-1:0]   a_hold;
  logic [W-1:0]   b_hold;
  logic           a_have;
  logic           b_have;
  logic           out_valid;
  logic [2*W-1:0] out_data;
  logic [1:0]     state;
  logic           pack_fire;
  logic           a_fire;
  logic           b_fire;
  logic           out_fire;
  logic           a_held;
  logic           b_held;

  assign state  = {a_have, b_have};
  assign a_held = (state == HAVE_A) || (state == BOTH);
  assign b_held = (state == HAVE_B) || (state == BOTH);

  // A pack may happen when both halves are present and the output slot is
  // free or being emptied this cycle; flush suppresses it.
  assign pack_fire = (state == BOTH) && (!out_valid || bus.out_ready) && !flush;

  // A held side can take a new nibble in the same cycle its old one is packed,
  // which is what makes one word per cycle possible.
  assign bus.a_ready = !flush && (!a_held || pack_fire);
  assign bus.b_ready = !flush && (!b_held || pack_fire);

  assign a_fire   = bus.a_valid && bus.a_ready;
  assign b_fire   = bus.b_valid && bus.b_ready;
  assign out_fire = out_valid && bus.out_ready;

  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign busy          = (state != EMPTY) || out_valid;

  // ---- input hold stage ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_have <= 1'b0;
      b_have <= 1'b0;
      a_hold <= '0;
      b_hold <= '0;
    end else if (flush) begin
      a_have <= 1'b0;
      b_have <= 1'b0;
    end else begin
      if (a_fire) begin
        a_hold <= bus.a_data;
        a_have <= 1'b1;
      end else if (pack_fire) begin
        a_have <= 1'b0;
      end
      if (b_fire) begin
        b_hold <= bus.b_data;
        b_have <= 1'b1;
      end else if (pack_fire) begin
        b_have <= 1'b0;
      end
    end
  end

  // ---- output word stage ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (pack_fire) begin
      out_valid <= 1'b1;
      out_data  <= {b_hold, a_hold};
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

`ifdef NIBBLE_PACK_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_count <= 16'h0000;
    end else if (out_fire) begin
      word_count <= word_count + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_nibble_pack_ctrl.sv
module tb_nibble_pack_ctrl;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic busy;
`ifdef NIBBLE_PACK_CNT_EN
  logic [15:0] word_count;
`endif

  int total = 0;
  int bad   = 0;
  logic [2*W-1:0] sb_q[$];

  nibble_pack_if #(.W(W)) bus ();

  nibble_pack_ctrl #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .bus        (bus),
    .busy       (busy)
`ifdef NIBBLE_PACK_CNT_EN
    ,
    .word_count (word_count)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every output handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      logic [2*W-1:0] want;
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL word: got out_data=%h, no word expected", bus.out_data);
      end else begin
        want = sb_q.pop_front();
        if (bus.out_data !== want) begin
          bad++;
          $display("FAIL word: got out_data=%h, expected %h", bus.out_data, want);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic drive(input logic av, input logic [W-1:0] ad,
                       input logic bv, input logic [W-1:0] bd);
    bus.a_valid = av;
    bus.a_data  = ad;
    bus.b_valid = bv;
    bus.b_data  = bd;
  endtask

  initial begin
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, '0, 1'b0, '0);

    // Reset values while rst_n is low
    #3;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'h00);
    chk("rst_busy",      32'(busy),          32'd0);
    chk("rst_a_ready",   32'(bus.a_ready),   32'd1);
    chk("rst_b_ready",   32'(bus.b_ready),   32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Same-cycle pair: 0x3 / 0xA -> 0xA3, two edges after presentation, one cycle
    drive(1'b1, 4'h3, 1'b1, 4'hA);
    sb_q.push_back(8'hA3);
    neg();
    chk("t1_a_ready", 32'(bus.a_ready), 32'd1);
    chk("t1_b_ready", 32'(bus.b_ready), 32'd1);
    tick();
    drive(1'b0, '0, 1'b0, '0);
    neg();
    chk("t1_valid_e1", 32'(bus.out_valid), 32'd0);
    chk("t1_busy_e1",  32'(busy),          32'd1);
    tick();
    neg();
    chk("t1_valid_e2", 32'(bus.out_valid), 32'd1);
    chk("t1_data_e2",  32'(bus.out_data),  32'hA3);
    tick();
    neg();
    chk("t1_valid_e3", 32'(bus.out_valid), 32'd0);
    chk("t1_busy_e3",  32'(busy),          32'd0);

    // b first, a three cycles later: 0x5C; a second b is blocked meanwhile
    tick();
    drive(1'b0, '0, 1'b1, 4'h5);
    sb_q.push_back(8'h5C);
    tick();
    drive(1'b0, '0, 1'b1, 4'h6);
    neg();
    chk("t2_b_blocked0", 32'(bus.b_ready), 32'd0);
    tick();
    neg();
    chk("t2_b_blocked1", 32'(bus.b_ready), 32'd0);
    tick();
    drive(1'b1, 4'hC, 1'b0, '0);
    neg();
    chk("t2_b_blocked2", 32'(bus.b_ready), 32'd0);
    chk("t2_a_ready",    32'(bus.a_ready), 32'd1);
    tick();
    drive(1'b0, '0, 1'b0, '0);
    neg();
    chk("t2_valid_pre", 32'(bus.out_valid), 32'd0);
    tick();
    neg();
    chk("t2_valid", 32'(bus.out_valid), 32'd1);
    tick();

    // Back-pressure: 0x21 held for 4 cycles while new nibbles wait
    bus.out_ready = 1'b0;
    drive(1'b1, 4'h1, 1'b1, 4'h2);
    sb_q.push_back(8'h21);
    tick();
    drive(1'b1, 4'h4, 1'b1, 4'h3);
    sb_q.push_back(8'h34);
    neg();
    chk("t3_a_ready_fire", 32'(bus.a_ready), 32'd1);
    tick();
    drive(1'b1, 4'h6, 1'b1, 4'h5);
    for (int i = 0; i < 4; i++) begin
      neg();
      chk("t3_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("t3_hold_data",  32'(bus.out_data),  32'h21);
      chk("t3_a_blocked",  32'(bus.a_ready),   32'd0);
      chk("t3_b_blocked",  32'(bus.b_ready),   32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    sb_q.push_back(8'h56);
    neg();
    chk("t3_a_ready_rel", 32'(bus.a_ready), 32'd1);
    tick();
    drive(1'b0, '0, 1'b0, '0);
    neg();
    chk("t3_next_valid", 32'(bus.out_valid), 32'd1);
    chk("t3_next_data",  32'(bus.out_data),  32'h34);
    tick();
    neg();
    chk("t3_last_data", 32'(bus.out_data), 32'h56);
    tick();
    neg();
    chk("t3_drained", 32'(bus.out_valid), 32'd0);

    // Flush discards a held 0x7; next pair gives 0x21
    tick();
    drive(1'b1, 4'h7, 1'b0, '0);
    tick();
    drive(1'b0, '0, 1'b0, '0);
    neg();
    chk("t4_busy_held", 32'(busy), 32'd1);
    tick();
    flush = 1'b1;
    neg();
    chk("t4_flush_a_ready", 32'(bus.a_ready), 32'd0);
    chk("t4_flush_b_ready", 32'(bus.b_ready), 32'd0);
    tick();
    flush = 1'b0;
    neg();
    chk("t4_busy_flushed", 32'(busy), 32'd0);
    tick();
    drive(1'b1, 4'h1, 1'b1, 4'h2);
    sb_q.push_back(8'h21);
    tick();
    drive(1'b0, '0, 1'b0, '0);
    tick();
    neg();
    chk("t4_valid_21", 32'(bus.out_valid), 32'd1);
    tick();

    // Flush beats simultaneous valids
    drive(1'b1, 4'h5, 1'b1, 4'h5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0, 1'b0, '0);
    neg();
    chk("t4_flush_vs_valid", 32'(busy), 32'd0);
    tick();

    // Flush beats a pending BOTH pack
    drive(1'b1, 4'h8, 1'b1, 4'h9);
    tick();
    drive(1'b0, '0, 1'b0, '0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    neg();
    chk("t4_flush_both_valid", 32'(bus.out_valid), 32'd0);
    chk("t4_flush_both_busy",  32'(busy),          32'd0);
    tick();

    // Reset mid-operation: BOTH held and a word waiting
    bus.out_ready = 1'b0;
    drive(1'b1, 4'h1, 1'b1, 4'h1);
    tick();
    drive(1'b1, 4'h2, 1'b1, 4'h2);
    tick();
    drive(1'b0, '0, 1'b0, '0);
    neg();
    chk("t5_pre_valid", 32'(bus.out_valid), 32'd1);
    chk("t5_pre_busy",  32'(busy),          32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid",   32'(bus.out_valid), 32'd0);
    chk("t5_rst_data",    32'(bus.out_data),  32'h00);
    chk("t5_rst_busy",    32'(busy),          32'd0);
    chk("t5_rst_a_ready", 32'(bus.a_ready),   32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      neg();
      chk("t5_no_word", 32'(bus.out_valid), 32'd0);
      tick();
    end

    // Streaming: one word per cycle
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 4'(i), 1'b1, 4'(15 - i));
      sb_q.push_back({4'(15 - i), 4'(i)});
      neg();
      chk("t6_a_ready", 32'(bus.a_ready), 32'd1);
      chk("t6_b_ready", 32'(bus.b_ready), 32'd1);
      if (i >= 2) chk("t6_stream_valid", 32'(bus.out_valid), 32'd1);
      tick();
    end
    drive(1'b0, '0, 1'b0, '0);
    repeat (3) tick();

`ifdef NIBBLE_PACK_CNT_EN
    // Counter wrap: 65537 handshakes leave word_count at 1
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      drive(1'b1, 4'(i), 1'b1, 4'(i >> 4));
      sb_q.push_back({4'(i >> 4), 4'(i)});
      tick();
    end
    drive(1'b0, '0, 1'b0, '0);
    repeat (3) tick();
    neg();
    chk("cnt_wrap", 32'(word_count), 32'h0001);
`endif

    repeat (2) tick();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nibble_pack_ctrl.md
NIBBLE_PACK_CTRL -- requirements
Module: nibble_pack_ctrl

Interface
REQ-001 SHALL have parameter W, default 4: nibble width; out_data width is 2*W.
REQ-002 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port a_valid, input, 1: low-half requester has a nibble.
REQ-005 SHALL have port a_data, input, W: low-half nibble.
REQ-006 SHALL have port a_ready, output, 1: low-half nibble accepted when a_valid & a_ready.
REQ-007 SHALL have port b_valid, input, 1: high-half requester has a nibble.
REQ-008 SHALL have port b_data, input, W: high-half nibble.
REQ-009 SHALL have port b_ready, output, 1: high-half nibble accepted when b_valid & b_ready.
REQ-010 SHALL have port flush, input, 1: synchronous discard of partially collected nibbles.
REQ-011 SHALL have port out_valid, output, 1: packed word available.
REQ-012 SHALL have port out_data, output, 2*W: packed word {b_nibble, a_nibble}, b in upper half.
REQ-013 SHALL have port out_ready, input, 1: consumer accepts when out_valid & out_ready.
REQ-014 SHALL have port busy, output, 1: high when any hold flag or out_valid is set.

Function
REQ-015 SHALL hold one nibble per side in registers a_hold/b_hold with flags a_have/b_have; the state is derived from the flags: EMPTY (0,0), HAVE_A (1,0), HAVE_B (0,1), BOTH (1,1).
REQ-016 SHALL define pack_fire = a_have & b_have & (~out_valid | out_ready).
REQ-017 SHALL drive a_ready = ~flush & (~a_have | pack_fire), and drive b_ready the same way using b_have; ready therefore depends combinationally on out_ready.
REQ-018 SHALL, on an a handshake, load a_hold and set a_have; on pack_fire without a new a handshake, clear a_have; b side likewise.
REQ-019 SHALL, on pack_fire, load out_data = {b_hold, a_hold} and set out_valid on the next edge.
REQ-020 SHALL clear out_valid after an out handshake when pack_fire is low, and keep it set when pack_fire is high (back-to-back words).
REQ-021 SHALL keep out_data and out_valid stable while out_valid & ~out_ready.
REQ-022 SHALL deliver the word one edge after the last needed nibble is accepted, i.e. out_valid is high in the cycle after pack_fire.
REQ-023 SHALL sustain one packed word per cycle when both sides are valid every cycle and out_ready is held high.
REQ-024 SHALL accept nibbles on either side in any order; a second nibble on a side that is already held is blocked (ready low) until pack_fire.
REQ-025 SHALL, when flush is high, clear a_have and b_have at the next edge, accept no nibbles, and inhibit pack_fire; out_valid and out_data are unaffected.
REQ-026 SHALL make flush take priority over simultaneous valid inputs and over a pending BOTH pack.

Reset
REQ-027 SHALL, while rst_n is low, force a_have=0, b_have=0, out_valid=0, out_data=0, a_hold=0, b_hold=0, busy=0; a_ready=b_ready=1 when flush is low.
REQ-028 SHALL discard partial nibbles and any undelivered word when reset asserts mid-operation, and resume in EMPTY on the first edge after rst_n deasserts.

Configuration
REQ-029 SHALL, with macro NIBBLE_PACK_CNT_EN defined, add output word_count[15:0]: reset 0, incremented on each out handshake, wrapping 0xFFFF->0x0000.
REQ-030 SHALL, without NIBBLE_PACK_CNT_EN, have no word_count port and no counter logic; all other behaviour is identical.

Verification
REQ-031 SHALL cover: a=0x3 and b=0xA accepted in the same cycle with out_ready=1 -> out_data=0xA3 and out_valid high exactly 2 edges later for 1 cycle.
REQ-032 SHALL cover: b=0x5 accepted, then a=0xC accepted 3 cycles later -> out_data=0x5C; b_ready stays low while a new b_valid is held in between.
REQ-033 SHALL cover: out_ready=0 for 4 cycles with 0x21 pending and both sides presenting new nibbles -> 0x21 held stable, a_ready=b_ready=0 once both held, next word follows on the cycle after out_ready=1.
REQ-034 SHALL cover: a=0x7 held then flush pulsed -> a_have cleared, a later pair 0x1/0x2 yields 0x21 (not 0x27).
REQ-035 SHALL cover: rst_n low while in BOTH with out_valid=1 -> all outputs at reset values immediately, no word delivered after release.
REQ-036 SHALL cover (NIBBLE_PACK_CNT_EN): 65537 out handshakes -> word_count=0x0001.
